// File: rtl/nested_call_responder_pkg.sv
// Shared types for the nested-call responder: op codes, default widths,
// the slot record layout and the per-stage op masks.
package nested_call_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_ADD_ONE = 2'd0,
    OP_ADD_TWO = 2'd1,
    OP_NESTED  = 2'd2,
    OP_PASS    = 2'd3
  } op_e;

  typedef struct packed {
    logic                 valid;
    op_e                  op;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_WIDTH-1:0] data;
  } slot_t;

  // Mask bit n set means op code n receives the stage increment.
  localparam logic [3:0] MASK_S1 = 4'b0110;  // ADD_TWO, NESTED
  localparam logic [3:0] MASK_S2 = 4'b0101;  // ADD_ONE, NESTED

endpackage

// File: rtl/nested_call_responder_if.sv
// Request/response handshake bundle for the nested-call responder.
// master: initiator side (drives requests, accepts responses)
// slave : responder side
interface nested_call_responder_if
  import nested_call_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) ();

  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [TAG_W-1:0] req_tag;
  logic [WIDTH-1:0] req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_tag, req_data, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_data, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data
  );

endinterface

// File: rtl/nested_call_responder_call_stage.sv
// One elastic slot register. Loads its input entry when adv is high,
// adding INC to the data for ops whose bit is set in OP_MASK.
// Ports: clock/reset, in_* (incoming entry), adv (slot may move),
//        out_* (held entry).
module call_stage
  import nested_call_pkg::*;
#(
  parameter int         WIDTH   = DEF_WIDTH,
  parameter int         TAG_W   = DEF_TAG_W,
  parameter int         INC     = 0,
  parameter logic [3:0] OP_MASK = 4'b0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  op_e              in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] in_data,
  input  logic             adv,
  output logic             out_valid,
  output op_e              out_op,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= OP_ADD_ONE;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      // Payload only moves with a real entry; a bubble just clears valid.
      if (in_valid) begin
        out_op   <= in_op;
        out_tag  <= in_tag;
        out_data <= in_data + (OP_MASK[in_op] ? INC_V : '0);
      end
    end
  end

endmodule

// File: rtl/nested_call_responder.sv
// Elastic in-order responder: request -> S1 (+2 stage) -> S2 (+1 stage)
// -> OUT response register. Three entries of capacity, full throughput.
// Ports: clock, reset (async, active-high), bus (slave side of the
// handshake bundle), resp_count (completed responses, wraps), busy.
module nested_call_responder
  import nested_call_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  nested_call_responder_if.slave  bus,
  output logic [CNT_W-1:0]        resp_count,
  output logic                    busy
);

  logic             s1_valid, s2_valid, out_valid;
  op_e              s1_op, s2_op_unused;
  logic [TAG_W-1:0] s1_tag, s2_tag, out_tag;
  logic [WIDTH-1:0] s1_data, s2_data, out_data;
  logic             out_adv, s2_adv, s1_adv;

  // Ready ripples back from the consumer; this is the only
  // combinational path through the block.
  assign out_adv = !out_valid || bus.resp_ready;
  assign s2_adv  = !s2_valid  || out_adv;
  assign s1_adv  = !s1_valid  || s2_adv;
  assign bus.req_ready = s1_adv;

  call_stage #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .INC(2), .OP_MASK(MASK_S1)
  ) u_s1 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (bus.req_valid),
    .in_op    (bus.req_op),
    .in_tag   (bus.req_tag),
    .in_data  (bus.req_data),
    .adv      (s1_adv),
    .out_valid(s1_valid),
    .out_op   (s1_op),
    .out_tag  (s1_tag),
    .out_data (s1_data)
  );

  call_stage #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .INC(1), .OP_MASK(MASK_S2)
  ) u_s2 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (s1_valid),
    .in_op    (s1_op),
    .in_tag   (s1_tag),
    .in_data  (s1_data),
    .adv      (s2_adv),
    .out_valid(s2_valid),
    .out_op   (s2_op_unused),
    .out_tag  (s2_tag),
    .out_data (s2_data)
  );

  // OUT slot: the op is fully consumed by now, so only tag/data are kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (out_adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_tag  <= s2_tag;
        out_data <= s2_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_count <= '0;
    end else if (out_valid && bus.resp_ready) begin
      resp_count <= resp_count + CNT_W'(1);
    end
  end

  assign bus.resp_valid = out_valid;
  assign bus.resp_tag   = out_tag;
  assign bus.resp_data  = out_data;
  assign busy           = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_nested_call_responder.sv
// Self-checking bench for nested_call_responder: per-scenario tasks with
// a queue-based reference model of the expected responses.
module tb_nested_call_responder;
  import nested_call_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] resp_count;
  logic        busy;

  nested_call_responder_if #(.WIDTH(8), .TAG_W(4)) bus ();

  nested_call_responder #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .resp_count(resp_count),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] exp_q[$];
  logic [15:0] model_count;
  logic        acc, rsp, q_empty;
  logic [3:0]  got_tag, exp_tag;
  logic [7:0]  got_data, exp_data;

  function automatic logic [7:0] ref_result(input op_e op, input logic [7:0] d);
    case (op)
      OP_ADD_ONE: return d + 8'd1;
      OP_ADD_TWO: return d + 8'd2;
      OP_NESTED:  return d + 8'd3;
      default:    return d;
    endcase
  endfunction

  // Applies inputs for one cycle (called just after a falling edge),
  // records what handshakes happen at the next rising edge and keeps the
  // reference queue in step. Returns after the following falling edge.
  task automatic drive(input logic v, input op_e op, input logic [3:0] tag,
                       input logic [7:0] d, input logic rr);
    bus.req_valid  = v;
    bus.req_op     = op;
    bus.req_tag    = tag;
    bus.req_data   = d;
    bus.resp_ready = rr;
    #1;
    acc      = v && bus.req_ready;
    rsp      = bus.resp_valid && rr;
    got_tag  = bus.resp_tag;
    got_data = bus.resp_data;
    q_empty  = 1'b0;
    if (rsp) begin
      if (exp_q.size() == 0) begin
        q_empty  = 1'b1;
        exp_tag  = '0;
        exp_data = '0;
      end else begin
        {exp_tag, exp_data} = exp_q.pop_front();
      end
      model_count = model_count + 16'd1;
    end
    if (acc) exp_q.push_back({tag, ref_result(op, d)});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = OP_ADD_ONE; bus.req_tag = '0;
    bus.req_data = '0; bus.resp_ready = 1'b0;
    exp_q.delete();
    model_count = '0;
    #2;
    n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL por_resp_valid got %b exp 0", bus.resp_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL por_req_ready got %b exp 1", bus.req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL por_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (resp_count !== 16'd0) $display("FAIL por_count got %0d exp 0", resp_count); else n_pass++;
    n_checks++; if ({bus.resp_tag, bus.resp_data} !== 12'h000) $display("FAIL por_resp got %h exp 000", {bus.resp_tag, bus.resp_data}); else n_pass++;
    @(negedge clock);
    reset = 1'b0;

    drive(1'b1, OP_ADD_TWO, 4'd7, 8'h30, 1'b1);
    for (int c = 0; c < 4; c++) drive(1'b0, OP_PASS, 4'd0, 8'h00, 1'b1);
    n_checks++; if (resp_count !== 16'd1) $display("FAIL pre_count got %0d exp 1", resp_count); else n_pass++;

    for (int c = 0; c < 3; c++) drive(1'b1, OP_NESTED, 4'(c), 8'(c * 16), 1'b0);
    n_checks++; if (busy !== 1'b1) $display("FAIL full_busy got %b exp 1", busy); else n_pass++;
    n_checks++; if (bus.resp_valid !== 1'b1) $display("FAIL full_valid got %b exp 1", bus.resp_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL full_req_ready got %b exp 0", bus.req_ready); else n_pass++;

    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL mid_resp_valid got %b exp 0", bus.resp_valid); else n_pass++;
    n_checks++; if ({bus.resp_tag, bus.resp_data} !== 12'h000) $display("FAIL mid_resp got %h exp 000", {bus.resp_tag, bus.resp_data}); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL mid_req_ready got %b exp 1", bus.req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (resp_count !== 16'd0) $display("FAIL mid_count got %0d exp 0", resp_count); else n_pass++;
    exp_q.delete();
    model_count = '0;
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, OP_PASS, 4'd0, 8'h00, 1'b1);
      n_checks++; if (rsp !== 1'b0) $display("FAIL stale_resp cycle %0d got %b exp 0", c, rsp); else n_pass++;
    end
  endtask

  task automatic test_single();
    int lat = 0;
    drive(1'b1, OP_NESTED, 4'd3, 8'h10, 1'b1);
    n_checks++; if (acc !== 1'b1) $display("FAIL single_accept got %b exp 1", acc); else n_pass++;
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, OP_PASS, 4'd0, 8'h00, 1'b1);
      if (rsp && lat == 0) begin
        lat = c;
        n_checks++; if ({got_tag, got_data} !== {4'd3, 8'h13}) $display("FAIL single_resp got %h exp 313", {got_tag, got_data}); else n_pass++;
      end
    end
    n_checks++; if (lat != 3) $display("FAIL single_latency got %0d exp 3", lat); else n_pass++;
    n_checks++; if (resp_count !== 16'd1) $display("FAIL single_count got %0d exp 1", resp_count); else n_pass++;
  endtask

  task automatic test_ops();
    op_e        ops[4] = '{OP_ADD_ONE, OP_ADD_TWO, OP_NESTED, OP_PASS};
    logic [7:0] ds[4]  = '{8'hFF, 8'hFF, 8'hFE, 8'hA5};
    logic [7:0] ed[4]  = '{8'h00, 8'h01, 8'h01, 8'hA5};
    int n = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      if (c < 4) drive(1'b1, ops[c], 4'(c), ds[c], 1'b1);
      else       drive(1'b0, OP_PASS, 4'd0, 8'h00, 1'b1);
      if (rsp) begin
        n_checks++; if ({got_tag, got_data} !== {4'(n), ed[n]}) $display("FAIL ops_resp%0d got %h exp %h", n, {got_tag, got_data}, {4'(n), ed[n]}); else n_pass++;
        n++;
      end
    end
    n_checks++; if (n != 4) $display("FAIL ops_count got %0d exp 4", n); else n_pass++;
  endtask

  task automatic test_backpressure();
    op_e         o[6];
    logic [7:0]  d[6];
    int          k = 0;
    int          n = 0;
    logic [15:0] cnt0 = resp_count;
    for (int i = 0; i < 6; i++) begin
      o[i] = op_e'(2'($urandom_range(0, 3)));
      d[i] = 8'($urandom);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, o[k], 4'(4 + k), d[k], 1'b0);
      if (acc) k++;
      if (c >= 2) begin
        n_checks++;
        if (bus.resp_valid !== 1'b1 || {bus.resp_tag, bus.resp_data} !== exp_q[0])
          $display("FAIL bp_stall_hold cycle %0d got %b/%h exp 1/%h", c, bus.resp_valid, {bus.resp_tag, bus.resp_data}, exp_q[0]);
        else n_pass++;
      end
    end
    n_checks++; if (k != 3) $display("FAIL bp_accepted got %0d exp 3", k); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready got %b exp 0", bus.req_ready); else n_pass++;
    for (int c = 0; c < 30 && n < 5; c++) begin
      drive(k < 5, o[k], 4'(4 + k), d[k], 1'b1);
      if (acc) k++;
      if (rsp) begin
        n_checks++;
        if (q_empty || got_tag !== 4'(4 + n) || {got_tag, got_data} !== {exp_tag, exp_data})
          $display("FAIL bp_resp%0d got %h exp %h", n, {got_tag, got_data}, {exp_tag, exp_data});
        else n_pass++;
        n++;
      end
    end
    n_checks++; if (n != 5) $display("FAIL bp_resp_total got %0d exp 5", n); else n_pass++;
    n_checks++; if (resp_count !== cnt0 + 16'd5 || resp_count !== model_count) $display("FAIL bp_count got %0d exp %0d", resp_count, model_count); else n_pass++;
  endtask

  task automatic test_full_drain_accept();
    int n = 0;
    for (int c = 0; c < 3; c++) drive(1'b1, op_e'(2'($urandom_range(0, 3))), 4'(9 + c), 8'($urandom), 1'b0);
    n_checks++; if (bus.req_ready !== 1'b0 || busy !== 1'b1) $display("FAIL fd_full got ready %b busy %b exp 0/1", bus.req_ready, busy); else n_pass++;
    drive(1'b1, op_e'(2'($urandom_range(0, 3))), 4'd12, 8'($urandom), 1'b1);
    n_checks++; if ({acc, rsp} !== 2'b11) $display("FAIL fd_same_edge got acc %b rsp %b exp 1/1", acc, rsp); else n_pass++;
    n_checks++; if (q_empty || {got_tag, got_data} !== {exp_tag, exp_data}) $display("FAIL fd_resp got %h exp %h", {got_tag, got_data}, {exp_tag, exp_data}); else n_pass++;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    n_checks++; if ({busy, bus.resp_valid, bus.req_ready} !== 3'b110) $display("FAIL fd_after got busy/valid/ready %b exp 110", {busy, bus.resp_valid, bus.req_ready}); else n_pass++;
    for (int c = 0; c < 12 && n < 3; c++) begin
      drive(1'b0, OP_PASS, 4'd0, 8'h00, 1'b1);
      if (rsp) begin
        n_checks++; if (q_empty || {got_tag, got_data} !== {exp_tag, exp_data}) $display("FAIL fd_drain%0d got %h exp %h", n, {got_tag, got_data}, {exp_tag, exp_data}); else n_pass++;
        n++;
      end
    end
    n_checks++; if (n != 3 || busy !== 1'b0) $display("FAIL fd_drained got %0d busy %b exp 3/0", n, busy); else n_pass++;
  endtask

  task automatic test_stream();
    int         sent = 0;
    int         got = 0;
    int         bad = 0;
    op_e        op = op_e'(2'($urandom_range(0, 3)));
    logic [3:0] tag = 4'($urandom);
    logic [7:0] d = 8'($urandom);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    exp_q.delete();
    model_count = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4000 && got < 256; c++) begin
      drive(sent < 256, op, tag, d, 1'($urandom_range(0, 1)));
      if (acc) begin
        sent++;
        op  = op_e'(2'($urandom_range(0, 3)));
        tag = 4'($urandom);
        d   = 8'($urandom);
      end
      if (rsp) begin
        n_checks++;
        if (q_empty || {got_tag, got_data} !== {exp_tag, exp_data}) begin
          bad++;
          if (bad <= 10) $display("FAIL stream_resp%0d got %h exp %h", got, {got_tag, got_data}, {exp_tag, exp_data});
        end else n_pass++;
        got++;
      end
    end
    n_checks++; if (got != 256) $display("FAIL stream_total got %0d exp 256", got); else n_pass++;
    n_checks++; if (resp_count !== 16'd256) $display("FAIL stream_count got %0d exp 256", resp_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL stream_idle got busy %b exp 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_backpressure();
    test_full_drain_accept();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nested_call_responder.md
# nested_call_responder

Elastic, in-order responder for chained increment calls. An initiator issues a request with an operand, an op code and a tag. The block carries it through an add-two stage and then an add-one stage, and returns the result with the same tag. It is the serving end of the nested-call pattern: the initiator drives operands in, and this block computes and hands results back under valid/ready flow control.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- TAG_W, 4, request tag width
- CNT_W, 16, completed-response counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  2  0 ADD_ONE (+1), 1 ADD_TWO (+2), 2 NESTED (+2 then +1), 3 PASS (+0)
- req_tag  in  TAG_W  returned unchanged with the result
- req_data  in  WIDTH  operand
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts the result
- resp_tag  out  TAG_W  tag of the current result
- resp_data  out  WIDTH  result
- resp_count  out  CNT_W  number of completed response handshakes
- busy  out  1  any stage holds a valid entry

## Operation
- Three register slots: S1 (two-stage), S2 (one-stage), OUT (response register). Each slot holds valid, op, tag and data.
- S1 loads from the request on a req_valid && req_ready edge. It stores data + 2 if op is ADD_TWO or NESTED, otherwise data unchanged.
- S2 loads from S1. It stores data + 1 if op is ADD_ONE or NESTED, otherwise unchanged.
- OUT loads from S2 unchanged. resp_valid, resp_tag and resp_data are driven directly from OUT.
- Advance rules, evaluated combinationally:
  - out_adv = !OUT.valid || resp_ready
  - s2_adv = !S2.valid || out_adv
  - s1_adv = !S1.valid || s2_adv
  - req_ready = s1_adv
- A slot that advances without receiving a new entry becomes invalid. A slot that does not advance holds its entry.
- Arithmetic is modulo 2^WIDTH with carries discarded. Example: 0xFF NESTED gives 0x02.
- Ordering is strict FIFO. There is no reordering and no dropping.
- resp_count increments on each resp_valid && resp_ready edge and wraps from all-ones to 0.
- busy = S1.valid | S2.valid | OUT.valid.

## Timing
- Reset state: all valids 0, resp_tag 0, resp_data 0, resp_count 0, busy 0. req_ready is 1 during and after reset because every slot is empty.
- Reset asserted mid-operation discards all in-flight entries immediately. resp_valid falls without waiting for a clock edge. No partial response is ever presented.
- Latency with no backpressure: a request accepted at edge E0 reaches S1 at E0, S2 at E1 and OUT at E2. resp_valid is high in the cycle after E2.
- Throughput is one request per cycle in steady state with resp_ready held high.
- Capacity is 3 outstanding entries. With resp_ready held low, req_ready falls once S1, S2 and OUT are all valid.
- When full, a cycle with resp_ready = 1 and req_valid = 1 both drains one response and accepts one request on the same edge. There is no bubble.
- resp_data and resp_tag must stay stable while resp_valid && !resp_ready.
- The block takes no combinational path from req_* to resp_*. The only combinational path is from resp_ready to req_ready.

## Structure
- Package nested_call_pkg holds:
  - op enum: OP_ADD_ONE, OP_ADD_TWO, OP_NESTED, OP_PASS
  - default widths
  - a slot struct {valid, op, tag, data}
- Sub-module call_stage: one slot register with parameter INC (0..2) and an op-mask selecting which ops apply INC. It has in/adv/out ports and is instantiated twice, once for S1 (INC = 2) and once for S2 (INC = 1).
- OUT is a plain slot register in the top module.
- Expected size is about 200 lines of RTL.

## Test plan
- Reset: assert reset mid-stream with 3 entries in flight. Outputs must drop to 0 asynchronously, req_ready must read 1, resp_count must read 0, and no stale response may appear after release.
- Single call: NESTED, data 0x10, tag 3, resp_ready = 1. Expect resp_valid in the 3rd cycle after acceptance with data 0x13 and tag 3, and resp_count = 1.
- Op coverage and wrap: ADD_ONE 0xFF → 0x00, ADD_TWO 0xFF → 0x01, NESTED 0xFE → 0x01, PASS 0xA5 → 0xA5, with tags 0–3 returned in order.
- Backpressure: hold resp_ready = 0 and offer 5 requests. Only 3 may be accepted, with req_ready = 0 after the third. Then release resp_ready and check that all 5 responses return in order, resp_count = 5, and data is stable while stalled.
- Full-pipe simultaneous drain and accept: with the pipe full, pulse resp_ready for 1 cycle alongside req_valid. Exactly one response and one accept must occur on the same edge, and busy must stay 1.
- Streaming: 256 back-to-back random requests with random resp_ready at 50%. A scoreboard must match every tag/data pair and the final resp_count = 256.
